// File: rtl/pwl_activation_interp.sv
// Pipelined piecewise-linear activation (tanh / sigmoid) with a run-time loadable
// breakpoint table, odd/complementary symmetry for x < 0 and saturation past the table.
module pwl_activation_interp #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned FRAC_W     = 16,
   parameter int unsigned STEP_SHIFT = 14,
   parameter int unsigned ADDR_W     = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_x,
   input  logic                in_mode,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_y,
   input  logic                tbl_we,
   input  logic [ADDR_W:0]     tbl_addr,
   input  logic [DATA_W-1:0]   tbl_wdata,
   output logic                idle
);

   localparam int unsigned NSEG   = 1 << ADDR_W;
   localparam int unsigned IDX_W  = DATA_W - STEP_SHIFT;
   localparam int unsigned PROD_W = DATA_W + STEP_SHIFT + 2;
   localparam logic [DATA_W-1:0] ONE = DATA_W'(1) << FRAC_W;

   logic [DATA_W-1:0]     tbl_mem [NSEG+1];

   logic                  v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic                  sign1_q, sign1_d, mode1_q, mode1_d;
   logic [IDX_W-1:0]      idx1_q, idx1_d;
   logic [STEP_SHIFT-1:0] frac1_q, frac1_d;
   logic                  sign2_q, sign2_d, mode2_q, mode2_d, sat2_q, sat2_d;
   logic [STEP_SHIFT-1:0] frac2_q, frac2_d;
   logic [DATA_W-1:0]     base2_q, base2_d, next2_q, next2_d;
   logic [DATA_W-1:0]     out_y_q, out_y_d;

   logic                  advance_c, idle_c, tbl_wr_c, sat_c;
   logic [DATA_W-1:0]     abs_c, f_c, interp_c, y_c;
   logic [ADDR_W-1:0]     seg_c;
   logic signed [DATA_W:0]   d_c;
   logic signed [PROD_W-1:0] p_c;

   assign advance_c = !v3_q || out_ready;
   assign idle_c    = !(v1_q || v2_q || v3_q);
   assign in_ready  = advance_c;
   assign out_valid = v3_q;
   assign out_y     = out_y_q;
   assign idle      = idle_c;

   // Table updates only while the pipeline is empty, so no sample sees a mixed table.
   assign tbl_wr_c = tbl_we && idle_c && (tbl_addr <= (ADDR_W+1)'(NSEG));

   always_ff @(posedge clk) begin
      if (tbl_wr_c) tbl_mem[tbl_addr] <= tbl_wdata;
   end

   // Datapath: S1 magnitude split, S2 table read, S3 interpolate and apply symmetry.
   always_comb begin
      abs_c    = in_x[DATA_W-1] ? (DATA_W'(0) - in_x) : in_x;
      sat_c    = idx1_q >= IDX_W'(NSEG);
      seg_c    = idx1_q[ADDR_W-1:0];
      d_c      = $signed({next2_q[DATA_W-1], next2_q}) - $signed({base2_q[DATA_W-1], base2_q});
      p_c      = PROD_W'(d_c) * PROD_W'($signed({1'b0, frac2_q}));
      interp_c = base2_q + DATA_W'(p_c >>> STEP_SHIFT);
      f_c      = sat2_q ? base2_q : interp_c;
      if (!sign2_q)     y_c = f_c;
      else if (mode2_q) y_c = ONE - f_c;
      else              y_c = DATA_W'(0) - f_c;
   end

   always_comb begin
      v1_d    = v1_q;    v2_d    = v2_q;    v3_d    = v3_q;
      sign1_d = sign1_q; mode1_d = mode1_q; idx1_d  = idx1_q;  frac1_d = frac1_q;
      sign2_d = sign2_q; mode2_d = mode2_q; sat2_d  = sat2_q;  frac2_d = frac2_q;
      base2_d = base2_q; next2_d = next2_q; out_y_d = out_y_q;
      if (advance_c) begin
         v1_d    = in_valid;
         v2_d    = v1_q;
         v3_d    = v2_q;
         sign1_d = in_x[DATA_W-1];
         mode1_d = in_mode;
         idx1_d  = abs_c[DATA_W-1:STEP_SHIFT];
         frac1_d = abs_c[STEP_SHIFT-1:0];
         sign2_d = sign1_q;
         mode2_d = mode1_q;
         sat2_d  = sat_c;
         frac2_d = frac1_q;
         base2_d = sat_c ? tbl_mem[NSEG] : tbl_mem[seg_c];
         next2_d = tbl_mem[{1'b0, seg_c} + (ADDR_W+1)'(1)];
         if (v2_q) out_y_d = y_c;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q    <= 1'b0; v2_q    <= 1'b0; v3_q    <= 1'b0;
         sign1_q <= 1'b0; mode1_q <= 1'b0; idx1_q  <= '0;   frac1_q <= '0;
         sign2_q <= 1'b0; mode2_q <= 1'b0; sat2_q  <= 1'b0; frac2_q <= '0;
         base2_q <= '0;   next2_q <= '0;   out_y_q <= '0;
      end else begin
         v1_q    <= v1_d;    v2_q    <= v2_d;    v3_q    <= v3_d;
         sign1_q <= sign1_d; mode1_q <= mode1_d; idx1_q  <= idx1_d;  frac1_q <= frac1_d;
         sign2_q <= sign2_d; mode2_q <= mode2_d; sat2_q  <= sat2_d;  frac2_q <= frac2_d;
         base2_q <= base2_d; next2_q <= next2_d; out_y_q <= out_y_d;
      end
   end

endmodule

// File: tb/tb_pwl_activation_interp.sv
// Self-checking bench for pwl_activation_interp: directed vectors, handshake corner
// cases and randomized traffic against an arithmetic reference model.
module tb_pwl_activation_interp;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_mode, out_valid, out_ready, tbl_we, idle;
   logic [31:0] in_x, out_y, tbl_wdata;
   logic [4:0]  tbl_addr;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_out   = 0;
   longint      tbl_m [17];
   logic [31:0] exp_q [$];

   typedef struct {
      logic [31:0] x;
      logic        mode;
      logic [31:0] exp;
      string       name;
   } vec_t;
   vec_t vecs [10];

   pwl_activation_interp dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
      .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
      .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .idle(idle)
   );

   always #5 clk = ~clk;

   // Reference: f(|x|) by linear interpolation with floor division, then symmetry.
   function automatic logic [31:0] ref_y(input logic [31:0] x, input logic mode);
      longint xs, a, idx, frac, num, q, f;
      xs   = longint'($signed(x));
      a    = (xs < 0) ? -xs : xs;
      idx  = a / 16384;
      frac = a % 16384;
      if (idx >= 16) f = tbl_m[16];
      else begin
         num = (tbl_m[int'(idx) + 1] - tbl_m[int'(idx)]) * frac;
         q   = num / 16384;
         if ((num % 16384 != 0) && (num < 0)) q = q - 1;
         f   = tbl_m[int'(idx)] + q;
      end
      if (xs < 0) f = mode ? (65536 - f) : -f;
      return f[31:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Handshakes are evaluated mid-cycle; they take effect on the following rising edge.
   always @(negedge clk) begin
      if (rst) exp_q.delete();
      else begin
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL scoreboard: unexpected output 0x%08h, expected none", out_y);
            end else check("scoreboard", out_y, exp_q.pop_front());
         end
         if (in_valid && in_ready) exp_q.push_back(ref_y(in_x, in_mode));
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic tbl_write(input int addr, input logic [31:0] data, input bit upd);
      tbl_we = 1'b1; tbl_addr = 5'(addr); tbl_wdata = data;
      if (upd) tbl_m[addr] = longint'($signed(data));
      step();
      tbl_we = 1'b0;
   endtask

   task automatic send(input logic [31:0] x, input logic m, input bit rnd_ready);
      bit acc = 1'b0;
      in_valid = 1'b1; in_x = x; in_mode = m;
      for (int t = 0; t < 200 && !acc; t++) begin
         if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
         #1;
         acc = in_ready;
         step();
      end
      in_valid = 1'b0;
      if (!acc) check("send_timeout", 32'(acc), 32'd1);
   endtask

   task automatic wait_result(input string name, input logic [31:0] exp);
      int n = 0;
      while (!out_valid && n < 10) begin step(); n++; end
      check({name, "_latency"}, 32'(n), 32'd2);
      check(name, out_y, exp);
      step();
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int t = 0; t < 100 && !(exp_q.size() == 0 && idle); t++) step();
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic run_vec(input logic [31:0] x, input logic m, input logic [31:0] exp,
                          input string name);
      out_ready = 1'b1;
      send(x, m, 1'b0);
      wait_result(name, exp);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, expected $finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] y0;
      int          base_out, seen;
      logic [31:0] rx;

      vecs[0] = '{32'h0000_6000, 1'b0, 32'h0000_1800, "interp"};
      vecs[1] = '{32'hFFFF_A000, 1'b0, 32'hFFFF_E800, "tanh_neg"};
      vecs[2] = '{32'hFFFF_A000, 1'b1, 32'h0000_E800, "sigm_neg"};
      vecs[3] = '{32'h0005_0000, 1'b0, 32'h0001_0000, "sat_pos"};
      vecs[4] = '{32'h8000_0000, 1'b0, 32'hFFFF_0000, "sat_min_tanh"};
      vecs[5] = '{32'h8000_0000, 1'b1, 32'h0000_0000, "sat_min_sigm"};
      vecs[6] = '{32'h0004_0000, 1'b0, 32'h0001_0000, "sat_edge"};
      vecs[7] = '{32'h0003_FFFF, 1'b0, 32'h0000_FFFF, "last_seg"};
      vecs[8] = '{32'hFFFF_FFFF, 1'b0, 32'h0000_0000, "tanh_m1lsb"};
      vecs[9] = '{32'hFFFF_FFFF, 1'b1, 32'h0001_0000, "sigm_m1lsb"};

      rst = 1'b1; in_valid = 1'b0; in_x = '0; in_mode = 1'b0; out_ready = 1'b0;
      tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_y", out_y, 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
      step(); rst = 1'b0; step();

      for (int i = 0; i <= 16; i++) tbl_write(i, 32'(i * 4096), 1'b1);

      for (int i = 0; i < 10; i++) run_vec(vecs[i].x, vecs[i].mode, vecs[i].exp, vecs[i].name);

      // Table gating: busy write, out-of-range write, idle write, same-edge write.
      out_ready = 1'b1;
      send(32'h0000_4000, 1'b0, 1'b0);
      tbl_write(1, 32'h0000_DEAD, 1'b0);
      drain();
      run_vec(32'h0000_4000, 1'b0, 32'd4096, "gate_busy");
      tbl_write(17, 32'h0000_1111, 1'b0);
      run_vec(32'h0000_4000, 1'b0, 32'd4096, "gate_addr");
      tbl_write(1, 32'd0, 1'b1);
      run_vec(32'h0000_4000, 1'b0, 32'd0, "gate_idle");
      tbl_we = 1'b1; tbl_addr = 5'd2; tbl_wdata = 32'd12345; tbl_m[2] = 12345;
      in_valid = 1'b1; in_x = 32'h0000_8000; in_mode = 1'b0;
      step();
      tbl_we = 1'b0; in_valid = 1'b0;
      wait_result("same_edge_wr", 32'd12345);
      tbl_write(1, 32'd4096, 1'b1);
      tbl_write(2, 32'd8192, 1'b1);

      // Back-pressure: three held, fourth stalled for five cycles, then release.
      base_out = n_out;
      out_ready = 1'b0;
      send(32'h0000_1000, 1'b0, 1'b0);
      send(32'hFFFF_3000, 1'b1, 1'b0);
      send(32'h0001_2345, 1'b0, 1'b0);
      check("bp_full_ready", 32'(in_ready), 32'd0);
      y0 = out_y;
      in_valid = 1'b1; in_x = 32'h0000_2222; in_mode = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         check("bp_hold_ready", 32'(in_ready), 32'd0);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_y", out_y, y0);
      end
      out_ready = 1'b1;
      send(32'h0000_2222, 1'b1, 1'b0);
      send(32'hFFFC_0001, 1'b0, 1'b0);
      send(32'h7FFF_FFFF, 1'b1, 1'b0);
      drain();
      check("bp_count", 32'(n_out - base_out), 32'd6);

      // Reset with two samples in flight.
      out_ready = 1'b1;
      send(32'h0000_6000, 1'b0, 1'b0);
      send(32'h0000_7000, 1'b0, 1'b0);
      rst = 1'b1; #1;
      check("rstmid_out_valid", 32'(out_valid), 32'd0);
      check("rstmid_idle", 32'(idle), 32'd1);
      check("rstmid_out_y", out_y, 32'd0);
      step(); step(); rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin step(); if (out_valid) seen++; end
      check("rstmid_stale", 32'(seen), 32'd0);
      run_vec(32'h0000_8000, 1'b0, 32'd8192, "rst_tbl_kept");

      // Randomized traffic with a random table and random back-pressure.
      for (int i = 0; i <= 16; i++) tbl_write(i, $urandom, 1'b1);
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
         end else begin
            case ($urandom_range(0, 3))
               0:       rx = $urandom;
               1:       rx = 32'($urandom_range(0, 32'h50000));
               2:       rx = 32'd0 - 32'($urandom_range(0, 32'h50000));
               default: rx = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'(16384 * $urandom_range(0, 17));
            endcase
            send(rx, 1'($urandom_range(0, 1)), 1'b1);
         end
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
